checkpoint_sequencer: RTL
=========================

// Module: checkpoint_sequencer
// PURPOSE
//  Parametrised checkpoint monitor/sequencer for mprj_io progress codes.
//  Samples an asynchronous checkpoint bus from the user GPIOs and filters it.
//  Walks a programmable table of expected codes and drives a control word
//  (e.g. core boot/start strobes) on each matched step.
//  Reports pass/fail/timeout. Sits beside the user core in the harness/debug path.
// PARAMETERS
//  CHK_W      16      checkpoint code width
//  N_STEPS    8       max entries in step table
//  CTRL_W     8       control word width
//  TMO_W      24      timeout counter width
//  STABLE     2       cycles a synced code must hold before it is acted on (>=1)
//  FAIL_CODE  16'h0004 code forcing FAIL from any WAIT step
// PORTS
//  clock        in   1                 system clock
//  resetb       in   1                 async active-low reset
//  enable       in   1                 run request; low aborts to IDLE
//  checkbits_i  in   CHK_W             async checkpoint bus (pads)
//  step_code_i  in   N_STEPS*CHK_W     expected code per step, step0 in LSBs
//  step_ctrl_i  in   N_STEPS*CTRL_W    ctrl word applied on step match
//  num_steps_i  in   $clog2(N_STEPS+1) steps to run; clamped to N_STEPS
//  ctrl_init_i  in   CTRL_W            ctrl word while IDLE / at start
//  timeout_i    in   TMO_W             per-step cycle limit; 0 = disabled
//  ctrl_o       out  CTRL_W            control word to core
//  step_idx_o   out  $clog2(N_STEPS)   index of step being awaited
//  step_hit_o   out  1                 1-cycle pulse on each step match
//  busy_o       out  1                 high in WAIT
//  pass_o / fail_o / tmo_o  out 1 each sticky terminal status
// BEHAVIOUR
//  Reset: ctrl_o=0, step_idx_o=0, all flags 0, state IDLE, sync regs 0.
//  Input path: 2-FF sync of checkbits_i. Stability counter loads on change.
//    code_vld asserts when the synced value has held STABLE cycles.
//    Decision latency = 2 + STABLE cycles from pad change.
//  States: IDLE, WAIT, PASS, FAIL, TMO.
//  IDLE: ctrl_o=ctrl_init_i each cycle.
//    enable=1 -> WAIT, idx=0, timer=0; if clamped num_steps==0 -> PASS instead.
//  WAIT, priority high->low, evaluated each cycle with code_vld=1:
//    1) enable=0 -> IDLE, ctrl_o<=ctrl_init_i, flags cleared.
//    2) code==FAIL_CODE -> FAIL (wins even if equal to step code).
//    3) code==step_code[idx] -> step_hit_o=1, ctrl_o<=step_ctrl[idx], timer=0.
//       If idx==num_steps-1 -> PASS, else idx+1.
//    4) timeout_i!=0 and timer==timeout_i-1 -> TMO.
//    Else timer+1, saturating at all-ones.
//  A code matched on step k is not rematched on step k+1 until it changes.
//    (match requires new code_vld edge: filter re-arm on value change)
//    Repeated identical codes in consecutive steps are therefore unsupported.
//  PASS/FAIL/TMO: hold ctrl_o and flags; leave only via enable=0 -> IDLE.
//  Exactly one of pass/fail/tmo high in a terminal state; all low elsewhere.
//  num_steps_i, tables and timeout_i sampled live; must be static while busy.
//  resetb low at any time: immediate return to reset values.
// STRUCTURE
//  Package cps_pkg: state localparams (IDLE=0, WAIT=1, PASS=2, FAIL=3, TMO=4).
//  Sub-module chk_sync_filter: 2-FF sync, stability counter, code/code_vld/new flag.
//  Top: FSM, step index, timer, table mux.
// TESTING
//  T1 table {1,2,3} ctrl {06,06,26}, init 06; drive 1,2,3.
//     -> 3 hit pulses, ctrl_o 06->26 on step2, pass_o=1.
//  T2 after step1 drive 0004 -> fail_o=1, ctrl_o unchanged.
//     Repeat with step_code[1]=0004 -> still FAIL.
//  T3 timeout_i=100, stall on step1 -> tmo_o exactly 100 clk after step0 hit.
//     With timeout_i=0, 10k-cycle stall -> busy_o stays high.
//  T4 glitch: 1-cycle pulse of expected code with STABLE=2 -> no hit.
//     Hold 3 cycles -> hit 2+STABLE cycles after change.
//  T5 num_steps_i=0 -> PASS one cycle after enable.
//     num_steps_i=15 with N_STEPS=8 -> clamped, PASS after 8 hits.
//  T6 abort and reset: enable=0 mid-WAIT -> IDLE, ctrl_o=init next clk.
//     resetb pulse mid-WAIT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cps_pkg.sv
// Shared types for the checkpoint sequencer: FSM state encoding and a width helper.
package cps_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_PASS = 3'd2,
    ST_FAIL = 3'd3,
    ST_TMO  = 3'd4
  } cps_state_e;

  // Index width that stays legal (>=1 bit) even for a single-entry table.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chk_sync_filter.sv
// Synchronises the asynchronous checkpoint bus and qualifies a code once it has
// been stable for STABLE cycles; each stable value is offered once for matching.
module chk_sync_filter #(
  parameter int CHK_W  = 16,
  parameter int STABLE = 2
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [CHK_W-1:0] checkbits_i,
  input  logic             consume_i,
  output logic [CHK_W-1:0] code_o,
  output logic             code_vld_o,
  output logic             code_new_o
);

  localparam int CNT_W = $clog2(STABLE + 1);

  logic [CHK_W-1:0] sync1_q;
  logic [CHK_W-1:0] sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic             new_q;
  logic             changing;

  // sync2_q takes a different value at the next edge; restart the stability count.
  assign changing = (sync1_q != sync2_q);

  // Handshake: code_new_o stays high from the cycle the code becomes stable until
  // consume_i is sampled high or the code changes; consume_i is only legal while
  // code_new_o is high.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      new_q   <= 1'b0;
    end else begin
      sync1_q <= checkbits_i;
      sync2_q <= sync1_q;
      if (changing) begin
        cnt_q <= CNT_W'(1);
        new_q <= (STABLE == 1);
      end else begin
        if (cnt_q != CNT_W'(STABLE)) cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(STABLE - 1)) new_q <= 1'b1;
        else if (consume_i)              new_q <= 1'b0;
      end
    end
  end

  assign code_o     = sync2_q;
  assign code_vld_o = (cnt_q == CNT_W'(STABLE));
  assign code_new_o = new_q & code_vld_o;

endmodule

// File: rtl/checkpoint_sequencer.sv
// Walks a table of expected checkpoint codes from the user GPIOs, drives the
// per-step control word on each match and reports pass / fail / timeout.
module checkpoint_sequencer
  import cps_pkg::*;
#(
  parameter int CHK_W  = 16,
  parameter int N_STEPS = 8,
  parameter int CTRL_W = 8,
  parameter int TMO_W  = 24,
  parameter int STABLE = 2,
  parameter logic [CHK_W-1:0] FAIL_CODE = CHK_W'(16'h0004),
  localparam int NS_W  = $clog2(N_STEPS + 1),
  localparam int IDX_W = idx_width(N_STEPS)
) (
  input  logic                      clock,
  input  logic                      resetb,
  input  logic                      enable,
  input  logic [CHK_W-1:0]          checkbits_i,
  input  logic [N_STEPS*CHK_W-1:0]  step_code_i,
  input  logic [N_STEPS*CTRL_W-1:0] step_ctrl_i,
  input  logic [NS_W-1:0]           num_steps_i,
  input  logic [CTRL_W-1:0]         ctrl_init_i,
  input  logic [TMO_W-1:0]          timeout_i,
  output logic [CTRL_W-1:0]         ctrl_o,
  output logic [IDX_W-1:0]          step_idx_o,
  output logic                      step_hit_o,
  output logic                      busy_o,
  output logic                      pass_o,
  output logic                      fail_o,
  output logic                      tmo_o,
  output logic [STATE_W-1:0]        state_o
);

  cps_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TMO_W-1:0]  timer_q, timer_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              hit_q, hit_d;
  logic              consume;

  logic [CHK_W-1:0]  code;
  logic              code_vld;
  logic              code_new;
  logic [NS_W-1:0]   num_clamped;
  logic [CHK_W-1:0]  cur_code;
  logic [CTRL_W-1:0] cur_ctrl;
  logic              is_last;

  chk_sync_filter #(
    .CHK_W  (CHK_W),
    .STABLE (STABLE)
  ) u_filter (
    .clock       (clock),
    .resetb      (resetb),
    .checkbits_i (checkbits_i),
    .consume_i   (consume),
    .code_o      (code),
    .code_vld_o  (code_vld),
    .code_new_o  (code_new)
  );

  assign num_clamped = (num_steps_i > NS_W'(N_STEPS)) ? NS_W'(N_STEPS) : num_steps_i;
  assign cur_code    = step_code_i[idx_q*CHK_W +: CHK_W];
  assign cur_ctrl    = step_ctrl_i[idx_q*CTRL_W +: CTRL_W];
  assign is_last     = ((NS_W'(idx_q) + NS_W'(1)) == num_clamped);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    ctrl_d  = ctrl_q;
    hit_d   = 1'b0;
    consume = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ctrl_d  = ctrl_init_i;
        idx_d   = '0;
        timer_d = '0;
        if (enable) state_d = (num_clamped == '0) ? ST_PASS : ST_WAIT;
      end
      ST_WAIT: begin
        // Abort beats FAIL_CODE, which beats a step match, which beats timeout.
        if (!enable) begin
          state_d = ST_IDLE;
          ctrl_d  = ctrl_init_i;
          idx_d   = '0;
        end else if (code_vld && (code == FAIL_CODE)) begin
          state_d = ST_FAIL;
        end else if (code_new && (code == cur_code)) begin
          hit_d   = 1'b1;
          consume = 1'b1;
          ctrl_d  = cur_ctrl;
          timer_d = '0;
          if (is_last) state_d = ST_PASS;
          else         idx_d   = idx_q + IDX_W'(1);
        end else if ((timeout_i != '0) && (timer_q == timeout_i - TMO_W'(1))) begin
          state_d = ST_TMO;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TMO_W'(1);
        end
      end
      default: begin
        if (!enable) begin
          state_d = ST_IDLE;
          ctrl_d  = ctrl_init_i;
          idx_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      ctrl_q  <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      ctrl_q  <= ctrl_d;
      hit_q   <= hit_d;
    end
  end

  assign ctrl_o     = ctrl_q;
  assign step_idx_o = idx_q;
  assign step_hit_o = hit_q;
  assign busy_o     = (state_q == ST_WAIT);
  assign pass_o     = (state_q == ST_PASS);
  assign fail_o     = (state_q == ST_FAIL);
  assign tmo_o      = (state_q == ST_TMO);
  assign state_o    = state_q;

endmodule
